// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU (A) and load (B) requesters with a bounded-starvation
// priority for B, a one-cycle registered register-file write port, and a busy scoreboard.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        a_valid,
    input  logic [4:0]  a_wn,
    input  logic [31:0] a_d,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_wn,
    input  logic [31:0] b_d,
    output logic        b_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wn,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic        stall,
    output logic [31:0] busy
);
    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    logic [1:0]  starve_cnt_q, starve_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_wn_q, rf_wn_d;
    logic [31:0] rf_d_q, rf_d_d;
    logic [31:0] busy_q, busy_d;
    logic        force_b, a_hs, b_hs;

    always_comb begin
        force_b = b_valid && (starve_cnt_q == LIMIT);
        a_ready = !force_b;
        b_ready = force_b || !a_valid;
        a_hs    = a_valid && a_ready;
        b_hs    = b_valid && b_ready;

        starve_cnt_d = starve_cnt_q;
        if (!b_valid || b_hs)
            starve_cnt_d = 2'd0;
        else if (starve_cnt_q < LIMIT)
            starve_cnt_d = starve_cnt_q + 2'd1;

        // wn/d hold when idle; only the enable drops
        rf_we_d = 1'b0;
        rf_wn_d = rf_wn_q;
        rf_d_d  = rf_d_q;
        if (a_hs) begin
            rf_we_d = (a_wn != 5'd0);
            rf_wn_d = a_wn;
            rf_d_d  = a_d;
        end else if (b_hs) begin
            rf_we_d = (b_wn != 5'd0);
            rf_wn_d = b_wn;
            rf_d_d  = b_d;
        end

        // Clear first so a same-edge issue to the same register wins
        busy_d = busy_q;
        if (rf_we_q)
            busy_d[rf_wn_q] = 1'b0;
        if (iss_valid && (iss_wn != 5'd0))
            busy_d[iss_wn] = 1'b1;
        busy_d[0] = 1'b0;

        stall = ((rna != 5'd0) && busy_q[rna]) || ((rnb != 5'd0) && busy_q[rnb]);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            starve_cnt_q <= 2'd0;
            rf_we_q      <= 1'b0;
            rf_wn_q      <= 5'd0;
            rf_d_q       <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_wn_q      <= rf_wn_d;
            rf_d_q       <= rf_d_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wn = rf_wn_q;
    assign rf_d  = rf_d_q;
    assign busy  = busy_q;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive cycles requester B may lose arbitration before it is forced to win; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_wn  input  5  A destination register number.
REQ-006 a_d  input  32  A write data.
REQ-007 a_ready  output  1  A request accepted this cycle when a_valid=1.
REQ-008 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-009 b_wn  input  5  B destination register number.
REQ-010 b_d  input  32  B write data.
REQ-011 b_ready  output  1  B request accepted this cycle when b_valid=1.
REQ-012 rf_we  output  1  registered write enable to the register file.
REQ-013 rf_wn  output  5  registered write register number to the register file.
REQ-014 rf_d  output  32  registered write data to the register file.
REQ-015 iss_valid  input  1  an instruction issues that will write iss_wn later.
REQ-016 iss_wn  input  5  destination of the issuing instruction.
REQ-017 rna, rnb  input  5 each  source register numbers being read this cycle.
REQ-018 stall  output  1  combinational: a source register has a pending write.
REQ-019 busy  output  32  scoreboard vector; bit n=1 means a write to register n is outstanding.

Function
REQ-020 A handshake SHALL occur when x_valid=1 and x_ready=1; at most one handshake per cycle.
REQ-021 a_ready and b_ready SHALL be combinational; force_b = b_valid & (starve_cnt == STARVE_LIMIT).
REQ-022 a_ready SHALL be !force_b; b_ready SHALL be force_b | !a_valid.
REQ-023 starve_cnt (2 bits) SHALL increment, saturating at STARVE_LIMIT, when b_valid=1 and b_ready=0; it SHALL clear to 0 on a B handshake or when b_valid=0.
REQ-024 The handshake accepted in cycle N SHALL appear on rf_wn/rf_d in cycle N+1, with rf_we=1 only if the accepted wn != 0; latency is exactly 1 cycle.
REQ-025 A handshake with wn=0 SHALL be accepted and discarded: rf_we=0 in N+1, busy unchanged.
REQ-026 With no handshake in cycle N, rf_we SHALL be 0 in N+1; rf_wn/rf_d SHALL hold their previous values.
REQ-027 iss_valid=1 with iss_wn != 0 SHALL set busy[iss_wn] at the next edge; iss_wn=0 SHALL be ignored; busy[0] SHALL always read 0.
REQ-028 busy[rf_wn] SHALL clear at the edge that ends a cycle with rf_we=1; a reader in the following cycle sees the new register value and no stall.
REQ-029 If the same register is both set (issue) and cleared (commit) at one edge, set SHALL win.
REQ-030 stall SHALL be (rna != 0 & busy[rna]) | (rnb != 0 & busy[rnb]), using current busy only; no internal forwarding.
REQ-031 The block SHALL NOT block acceptance based on busy; it never drops a valid request with wn != 0.

Reset
REQ-032 clrn=0 SHALL asynchronously force rf_we=0, rf_wn=0, rf_d=0, busy=0, starve_cnt=0.
REQ-033 During reset, a_ready/b_ready SHALL follow REQ-022 with starve_cnt=0, and no handshake SHALL take effect.
REQ-034 Reset asserted mid-operation SHALL discard any registered write: rf_we=0 immediately, and pending busy bits are lost.
REQ-035 The first edge after clrn rises SHALL behave as a normal cycle with no pending state.

Verification
REQ-036 Single write: A valid wn=5 d=0xDEADBEEF in cycle 0 -> a_ready=1; cycle 1 rf_we=1 rf_wn=5 rf_d=0xDEADBEEF; cycle 2 rf_we=0.
REQ-037 Contention: A and B valid continuously, STARVE_LIMIT=3 -> A wins cycles 0,1,2; B wins cycle 3 (a_ready=0, b_ready=1); starve_cnt returns to 0; pattern repeats every 4 cycles.
REQ-038 Scoreboard: issue wn=7 cycle 0, rna=7 -> stall=1 from cycle 1; A handshake wn=7 cycle 3 -> rf_we cycle 4; busy[7]=0 and stall=0 in cycle 5.
REQ-039 Set/clear collision: rf_we=1 rf_wn=9 while iss_valid=1 iss_wn=9 -> busy[9]=1 after the edge.
REQ-040 Register 0: B valid wn=0, issue wn=0, rna=0 -> b_ready=1, next-cycle rf_we=0, busy=0, stall=0.
REQ-041 Reset mid-flight: handshake wn=3 cycle 0, clrn low in cycle 1 -> rf_we=0 immediately, busy=0, starve_cnt=0.
